// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: ARM condition codes, flag bit positions
// and FlagW group encodings.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_CV   = 2'b01;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;
  localparam int FLAGW_NZ_BIT = 1;
  localparam int FLAGW_CV_BIT = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition-field evaluator: Cond + {N,Z,C,V} -> pass/fail.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_eval
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_eval = 1'b0;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      // The reserved encoding never executes.
      COND_NV: cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Flag register, registered condition result and write gating for the multicycle core.
// Optional squashed-write counter is built only when COND_SQUASH_CNT_EN is defined.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [CNT_W-1:0] SquashCnt
);

  logic       cond_eval;
  logic [3:0] flags_reg;
  logic       cond_ex_reg;

  cond_check u_cond_check (
    .cond      (Cond),
    .flags     (flags_reg),
    .cond_eval (cond_eval)
  );

  // Flags are judged by the pre-edge condition, so an instruction's own flag
  // update never influences whether it is allowed to set them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg   <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      cond_ex_reg <= cond_eval;
      if (FlagW[FLAGW_NZ_BIT] & cond_eval)
        flags_reg[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[FLAGW_CV_BIT] & cond_eval)
        flags_reg[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign Flags    = flags_reg;
  assign CondEx   = cond_ex_reg;
  assign PCWrite  = NextPC | (PCS & cond_ex_reg);
  assign RegWrite = RegW & cond_ex_reg;
  assign MemWrite = MemW & cond_ex_reg;

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] squash_cnt_reg;
  logic             squash;

  assign squash = (RegW | MemW | (PCS & NextPC)) & ~cond_ex_reg;

  // Saturating: once all-ones the count stays put until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      squash_cnt_reg <= '0;
    else if (squash && (squash_cnt_reg != {CNT_W{1'b1}}))
      squash_cnt_reg <= squash_cnt_reg + 1'b1;
  end

  assign SquashCnt = squash_cnt_reg;
`else
  assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: per-cycle comparison against a flag/condition model
// plus hand-computed checks for reset, flag groups, squashing and counter saturation.
module tb_cond_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       Cond = 4'b1110;
  logic [3:0]       ALUFlags = 4'b0000;
  logic [1:0]       FlagW = 2'b00;
  logic             PCS = 1'b0;
  logic             NextPC = 1'b0;
  logic             RegW = 1'b0;
  logic             MemW = 1'b0;
  logic [3:0]       Flags;
  logic             CondEx;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [CNT_W-1:0] SquashCnt;

  int vectors = 0;
  int miscompares = 0;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Flags     (Flags),
    .CondEx    (CondEx),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .SquashCnt (SquashCnt)
  );

  always #5 clk = ~clk;

  // Condition truth by mnemonic pair: even codes test the base predicate,
  // odd codes its inverse; 1111 never passes.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  logic [3:0]       m_flags = 4'b0000;
  logic             m_condex = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flags  <= 4'b0000;
      m_condex <= 1'b0;
      m_cnt    <= '0;
    end else begin
      m_condex <= cond_ok(Cond, m_flags);
      if (FlagW[1] && cond_ok(Cond, m_flags)) m_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && cond_ok(Cond, m_flags)) m_flags[1:0] <= ALUFlags[1:0];
`ifdef COND_SQUASH_CNT_EN
      if ((RegW || MemW || (PCS && NextPC)) && !m_condex && (int'(m_cnt) < (2**CNT_W - 1)))
        m_cnt <= m_cnt + 1'b1;
`endif
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("flags",     16'(Flags),     16'(m_flags));
    chk("condex",    16'(CondEx),    16'(m_condex));
    chk("pcwrite",   16'(PCWrite),   16'(NextPC | (PCS & m_condex)));
    chk("regwrite",  16'(RegWrite),  16'(RegW & m_condex));
    chk("memwrite",  16'(MemWrite),  16'(MemW & m_condex));
    chk("squashcnt", 16'(SquashCnt), 16'(m_cnt));
  endtask

  // One transaction: compare mid-cycle, then cross the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    $display("txn t=%0t rst=%0b cond=%h flagw=%b alu=%h pcs=%0b npc=%0b rw=%0b mw=%0b -> flags=%h cex=%0b pcw=%0b rwr=%0b mwr=%0b sq=%0h",
             $time, reset, Cond, FlagW, ALUFlags, PCS, NextPC, RegW, MemW,
             Flags, CondEx, PCWrite, RegWrite, MemWrite, SquashCnt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    FlagW = 2'b00; PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    step();
    FlagW = 2'b00;
  endtask

  initial begin
    // Reset held with strobes active.
    reset = 1'b1; RegW = 1'b1; MemW = 1'b1; NextPC = 1'b1;
    step();
    step();
    chk("rst_flags",    16'(Flags),    16'h0);
    chk("rst_regwrite", 16'(RegWrite), 16'h0);
    chk("rst_memwrite", 16'(MemWrite), 16'h0);
    chk("rst_pcwrite",  16'(PCWrite),  16'h1);
    chk("rst_squash",   16'(SquashCnt), 16'h0);
    reset = 1'b0;
    idle_inputs();

    // Independent flag groups.
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0110;
    step();
    chk("grp_nz", 16'(Flags), 16'h4);
    FlagW = 2'b01; ALUFlags = 4'b1011;
    step();
    chk("grp_cv", 16'(Flags), 16'h7);
    FlagW = 2'b00;

    // Condition sweep over all flag and condition combinations.
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        step();
        if (f == 9 && c == 12) chk("gt_1001", 16'(CondEx), 16'h1);
        if (c == 15) chk("nv_never", 16'(CondEx), 16'h0);
      end
    end

    // Squashed branch and register write, from a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_flags(4'b0000);
    Cond = 4'b0000;
    step();
    PCS = 1'b1; NextPC = 1'b0;
    #1;
    chk("sq_pcwrite", 16'(PCWrite), 16'h0);
    step();
    chk("sq_cnt_pcs", 16'(SquashCnt), 16'h0);
    PCS = 1'b0; RegW = 1'b1;
    #1;
    chk("sq_regwrite", 16'(RegWrite), 16'h0);
    step();
`ifdef COND_SQUASH_CNT_EN
    chk("sq_cnt_regw", 16'(SquashCnt), 16'h1);
`else
    chk("sq_cnt_regw", 16'(SquashCnt), 16'h0);
`endif
    idle_inputs();

    // Same-instruction flag update: gate uses condition on old Z.
    load_flags(4'b0000);
    Cond = 4'b0001; FlagW = 2'b10; ALUFlags = 4'b0100;
    step();
    chk("same_flags", 16'(Flags), 16'h4);
    FlagW = 2'b00; RegW = 1'b1;
    #1;
    chk("same_regwrite", 16'(RegWrite), 16'h1);
    step();
    idle_inputs();

    // Saturation with the never condition.
    reset = 1'b1;
    step();
    reset = 1'b0;
    Cond = 4'b1111;
    step();
    MemW = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
    end
`ifdef COND_SQUASH_CNT_EN
    chk("sat_cnt", 16'(SquashCnt), 16'hF);
`else
    chk("sat_cnt", 16'(SquashCnt), 16'h0);
`endif
    reset = 1'b1;
    #1;
    chk("sat_rst_cnt", 16'(SquashCnt), 16'h0);
    step();
    reset = 1'b0;
    idle_inputs();

    // Reset asserted mid-instruction drops conditional writes immediately.
    load_flags(4'b1010);
    Cond = 4'b1110;
    step();
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    #1;
    chk("mid_regwrite_pre", 16'(RegWrite), 16'h1);
    reset = 1'b1;
    #1;
    chk("mid_regwrite", 16'(RegWrite), 16'h0);
    chk("mid_memwrite", 16'(MemWrite), 16'h0);
    chk("mid_pcwrite",  16'(PCWrite),  16'h0);
    chk("mid_flags",    16'(Flags),    16'h0);
    chk("mid_condex",   16'(CondEx),   16'h0);
    step();
    reset = 1'b0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
